// File: rtl/proc_pkg.sv
// proc_pkg: shared arbiter state encodings, port-index width and fixed cache port indices.
package proc_pkg;
  localparam int PORT_IDX_W  = 3;
  localparam int ICACHE_PORT = 0;
  localparam int DCACHE_PORT = 1;
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_RD_WAIT = 2'd1,
    ARB_WR_WAIT = 2'd2
  } arb_state_e;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational masked priority picker, first requester at or above ptr_i with wrap.
//   req_i  per-port request vector
//   ptr_i  scan start index
//   gnt_o  one-hot grant (zero when nothing requests)
//   idx_o  encoded winner index
//   any_o  at least one request present
module rr_picker
  import proc_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0]  req_i,
  input  logic [PORT_IDX_W-1:0] ptr_i,
  output logic [NUM_PORTS-1:0]  gnt_o,
  output logic [PORT_IDX_W-1:0] idx_o,
  output logic                  any_o
);
  localparam logic [PORT_IDX_W:0] NP = (PORT_IDX_W + 1)'(NUM_PORTS);
  logic [NUM_PORTS-1:0]  rot;
  logic [PORT_IDX_W-1:0] off;
  logic [PORT_IDX_W:0]   sum;
  logic [PORT_IDX_W:0]   wrapped;
  // rotate so bit 0 of rot is port ptr_i; the lowest set bit is then the winner's distance from ptr_i
  assign rot = NUM_PORTS'({req_i, req_i} >> ptr_i);
  always_comb begin
    off = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) if (rot[k]) off = PORT_IDX_W'(k);
  end
  assign sum     = {1'b0, ptr_i} + {1'b0, off};
  assign wrapped = (sum >= NP) ? sum - NP : sum;
  assign idx_o   = wrapped[PORT_IDX_W-1:0];
  assign any_o   = |req_i;
  assign gnt_o   = any_o ? (NUM_PORTS'(1) << idx_o) : '0;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter of NUM_PORTS cache requesters onto one memory port, one transaction at a time.
//   clk, rst                     clock, asynchronous active-low reset
//   req_rd/req_wr/req_addr/req_wline   per-port level requests, packed address and write line
//   rd_valid/rd_line/wr_done     one-hot completion pulses, broadcast read line
//   mem_rd_req/mem_rd_addr/mem_rdata/mem_rvalid           memory read channel
//   mem_wr_req/mem_wr_addr/mem_wr_line/mem_wr_done        memory write channel
//   MEM_ARB_FIXED_PRIO_EN        when defined, lowest port index always wins (rr pointer held at 0)
module mem_arbiter
  import proc_pkg::*;
#(
  parameter int NUM_PORTS        = 2,
  parameter int ARCH_BITS        = 32,
  parameter int MEMORY_LINE_BITS = 128
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_PORTS-1:0]                  req_rd,
  input  logic [NUM_PORTS-1:0]                  req_wr,
  input  logic [NUM_PORTS*ARCH_BITS-1:0]        req_addr,
  input  logic [NUM_PORTS*MEMORY_LINE_BITS-1:0] req_wline,
  output logic [NUM_PORTS-1:0]                  rd_valid,
  output logic [MEMORY_LINE_BITS-1:0]           rd_line,
  output logic [NUM_PORTS-1:0]                  wr_done,
  output logic                                  mem_rd_req,
  output logic [ARCH_BITS-1:0]                  mem_rd_addr,
  input  logic [MEMORY_LINE_BITS-1:0]           mem_rdata,
  input  logic                                  mem_rvalid,
  output logic                                  mem_wr_req,
  output logic [ARCH_BITS-1:0]                  mem_wr_addr,
  output logic [MEMORY_LINE_BITS-1:0]           mem_wr_line,
  input  logic                                  mem_wr_done
);
  arb_state_e                  state_q, state_d;
  logic [PORT_IDX_W-1:0]       grant_id_q, grant_id_d, rr_ptr_q, rr_ptr_d;
  logic [ARCH_BITS-1:0]        addr_q, addr_d, sel_addr;
  logic [MEMORY_LINE_BITS-1:0] line_q, line_d, sel_line;
  logic [NUM_PORTS-1:0]        pick_gnt;
  logic [PORT_IDX_W-1:0]       pick_idx;
  logic                        pick_any, pick_wr, grab, done;
  rr_picker #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req_i(req_rd | req_wr),
    .ptr_i(rr_ptr_q),
    .gnt_o(pick_gnt),
    .idx_o(pick_idx),
    .any_o(pick_any)
  );
  // a port raising both read and write is served as a write: the dirty eviction must precede the refill
  assign pick_wr = |(req_wr & pick_gnt);
  always_comb begin
    sel_addr = '0;
    sel_line = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick_gnt[i]) begin
        sel_addr = req_addr[i*ARCH_BITS +: ARCH_BITS];
        sel_line = req_wline[i*MEMORY_LINE_BITS +: MEMORY_LINE_BITS];
      end
    end
  end
  assign grab = (state_q == ARB_IDLE) && pick_any;
  assign done = ((state_q == ARB_RD_WAIT) && mem_rvalid) || ((state_q == ARB_WR_WAIT) && mem_wr_done);
  assign grant_id_d = grab ? pick_idx : grant_id_q;
  assign addr_d     = grab ? sel_addr : addr_q;
  assign line_d     = grab ? sel_line : line_q;
`ifdef MEM_ARB_FIXED_PRIO_EN
  assign rr_ptr_d = '0;
`else
  localparam logic [PORT_IDX_W-1:0] LAST_PORT = PORT_IDX_W'(NUM_PORTS - 1);
  assign rr_ptr_d = done ? ((grant_id_q == LAST_PORT) ? '0 : grant_id_q + 1'b1) : rr_ptr_q;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ARB_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:                 if (pick_any) state_d = pick_wr ? ARB_WR_WAIT : ARB_RD_WAIT;
      ARB_RD_WAIT, ARB_WR_WAIT: if (done) state_d = ARB_IDLE;
      default:                  state_d = ARB_IDLE;
    endcase
  end
  always_comb begin
    mem_rd_req  = state_q == ARB_RD_WAIT;
    mem_wr_req  = state_q == ARB_WR_WAIT;
    mem_rd_addr = mem_rd_req ? addr_q : '0;
    mem_wr_addr = mem_wr_req ? addr_q : '0;
    mem_wr_line = mem_wr_req ? line_q : '0;
    rd_valid    = (mem_rd_req && mem_rvalid) ? (NUM_PORTS'(1) << grant_id_q) : '0;
    wr_done     = (mem_wr_req && mem_wr_done) ? (NUM_PORTS'(1) << grant_id_q) : '0;
    rd_line     = mem_rdata;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      addr_q     <= '0;
      line_q     <= '0;
    end else begin
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      addr_q     <= addr_d;
      line_q     <= line_d;
    end
  end
endmodule
